gelato_wb_arbiter: RTL and testbench
====================================

GELATO_WB_ARBITER -- requirements
Module: gelato_wb_arbiter

Interface
REQ-001 SHALL expose parameter NUM_SRC, default 3, number of writeback requesters (compute, load/store, special units); legal range 2..8.
REQ-002 SHALL expose parameter THREAD_NUM, default 32, lanes per warp.
REQ-003 SHALL expose parameter WARP_W, default 5, width of warp number.
REQ-004 SHALL expose parameter REG_W, default 5, width of register number.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-008 SHALL have port src_valid  input  NUM_SRC  per-source writeback request.
REQ-009 SHALL have port src_data  input  NUM_SRC*THREAD_NUM*32  per-source lane results, source i at slice i.
REQ-010 SHALL have port src_warp  input  NUM_SRC*WARP_W  per-source warp number.
REQ-011 SHALL have port src_reg  input  NUM_SRC*REG_W  per-source destination register.
REQ-012 SHALL have port src_mask  input  NUM_SRC*THREAD_NUM  per-source thread mask.
REQ-013 SHALL have port src_grant  output  NUM_SRC  one-cycle pulse: source i payload accepted.
REQ-014 SHALL have port wb_valid  output  1  writeback register holds a pending entry.
REQ-015 SHALL have ports wb_data/wb_warp/wb_reg/wb_mask  output  THREAD_NUM*32/WARP_W/REG_W/THREAD_NUM  pending entry payload.
REQ-016 SHALL have port wb_caught  input  1  register file has consumed the pending entry this cycle.
REQ-017 SHALL have port wb_count  output  32  number of entries consumed since reset.

Function
REQ-018 SHALL implement states IDLE (wb_valid=0) and HOLD (wb_valid=1).
REQ-019 SHALL define slot free in a cycle as IDLE, or HOLD with wb_caught=1.
REQ-020 SHALL, when rdy=1, slot free and any src_valid set, grant exactly one source, latch its payload into wb_* at the next edge, pulse src_grant for that cycle only, and enter/stay in HOLD.
REQ-021 SHALL select round-robin: first valid source scanning last_grant+1, last_grant+2, ... modulo NUM_SRC; last_grant updates only on a grant.
REQ-022 SHALL, in HOLD with wb_caught=1 and no src_valid, return to IDLE with wb_valid=0 next cycle.
REQ-023 SHALL, in HOLD with wb_caught=0, hold all wb_* stable and assert no grant.
REQ-024 SHALL sustain one writeback per cycle when wb_caught is asserted each cycle the entry is valid.
REQ-025 SHALL ignore wb_caught while in IDLE (no count change).
REQ-026 SHALL increment wb_count by 1, wrapping modulo 2^32, on each cycle with rdy=1, wb_valid=1 and wb_caught=1.
REQ-027 SHALL, when rdy=0, issue no grant, ignore wb_caught, and hold state, last_grant, wb_* and wb_count.
REQ-028 SHALL generate src_grant combinationally from current state, rdy, wb_caught and src_valid; latency request-to-wb_valid is 1 cycle.
REQ-029 SHALL require a source to hold src_valid and payload stable until granted; violation is flagged by a simulation assertion, not handled.
REQ-030 SHALL pass a zero thread mask through unchanged (no filtering).
REQ-031 SHALL, when an illegal state is reached, report $fatal in simulation.

Reset
REQ-032 SHALL on rst_n low, asynchronously: state IDLE, wb_valid=0, wb_data/wb_warp/wb_reg/wb_mask=0, wb_count=0, last_grant=NUM_SRC-1 (source 0 first priority).
REQ-033 SHALL hold src_grant=0 during reset; reset mid-HOLD discards the pending entry without counting it.

Verification
REQ-034 Single request: src_valid=3'b010, warp 4, reg 7, mask all ones, wb_caught held 1 -> src_grant=3'b010 for one cycle, next cycle wb_valid=1 with warp 4/reg 7, then IDLE, wb_count=1.
REQ-035 Fairness: src_valid=3'b111 continuously, wb_caught=1 every cycle -> grant order 0,1,2,0,1,2, one per cycle, wb_count=6 after six consumes.
REQ-036 Backpressure: entry from source 2 pending, wb_caught=0 for 5 cycles with src_valid=3'b001 -> no grant, wb_* unchanged; wb_caught=1 -> same-cycle grant to source 0.
REQ-037 rdy freeze: rdy=0 for 3 cycles with src_valid=3'b111 and wb_caught=1 -> no grants, wb_count and wb_* unchanged; on rdy=1 arbitration resumes from saved last_grant.
REQ-038 Reset mid-HOLD: pending entry, assert rst_n=0 between edges -> wb_valid=0 immediately, wb_count=0; after release, src_valid=3'b101 -> source 0 granted first.
REQ-039 Counter wrap: preload via 2^32 consumes or force wb_count=32'hFFFFFFFF, one consume -> wb_count=0.

Source files
------------

// File: rtl/gelato_wb_arbiter.sv
// Writeback arbiter: round-robin selection among NUM_SRC result producers into a
// single-entry writeback register that the register file drains via wb_caught.
module gelato_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int THREAD_NUM = 32,
  parameter int WARP_W     = 5,
  parameter int REG_W      = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rdy,
  input  logic [NUM_SRC-1:0]               src_valid,
  input  logic [NUM_SRC*THREAD_NUM*32-1:0] src_data,
  input  logic [NUM_SRC*WARP_W-1:0]        src_warp,
  input  logic [NUM_SRC*REG_W-1:0]         src_reg,
  input  logic [NUM_SRC*THREAD_NUM-1:0]    src_mask,
  output logic [NUM_SRC-1:0]               src_grant,
  output logic                             wb_valid,
  output logic [THREAD_NUM*32-1:0]         wb_data,
  output logic [WARP_W-1:0]                wb_warp,
  output logic [REG_W-1:0]                 wb_reg,
  output logic [THREAD_NUM-1:0]            wb_mask,
  input  logic                             wb_caught,
  output logic [31:0]                      wb_count
);

  localparam int          DATA_W = THREAD_NUM * 32;
  localparam int          IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned NSRC   = NUM_SRC;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [IDX_W-1:0]    last_grant;
  logic [IDX_W-1:0]    sel;
  logic                found;
  logic                slot_free;
  logic                do_grant;
  logic [31:0]         count_q;
  logic [DATA_W-1:0]   pick_data;
  logic [WARP_W-1:0]   pick_warp;
  logic [REG_W-1:0]    pick_reg;
  logic [THREAD_NUM-1:0] pick_mask;

  // Scan starts one past the last winner so every requester is served in turn.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    sel   = last_grant;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      idx = (32'(last_grant) + k) % NSRC;
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  assign slot_free = (state == IDLE) || ((state == HOLD) && wb_caught);
  assign do_grant  = rst_n && rdy && slot_free && found;
  assign wb_valid  = (state == HOLD);
  assign wb_count  = count_q;

  always_comb begin
    src_grant = '0;
    if (do_grant) src_grant[sel] = 1'b1;
  end

  always_comb begin
    pick_data = src_data[32'(sel)*DATA_W +: DATA_W];
    pick_warp = src_warp[32'(sel)*WARP_W +: WARP_W];
    pick_reg  = src_reg[32'(sel)*REG_W +: REG_W];
    pick_mask = src_mask[32'(sel)*THREAD_NUM +: THREAD_NUM];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (do_grant) next_state = HOLD;
      HOLD:    if (rdy && wb_caught && !do_grant) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_SRC - 1);
      wb_data    <= '0;
      wb_warp    <= '0;
      wb_reg     <= '0;
      wb_mask    <= '0;
      count_q    <= '0;
    end else if (rdy) begin
      if (do_grant) begin
        last_grant <= sel;
        wb_data    <= pick_data;
        wb_warp    <= pick_warp;
        wb_reg     <= pick_reg;
        wb_mask    <= pick_mask;
      end
      if (wb_valid && wb_caught) count_q <= count_q + 32'd1;
    end
  end

`ifndef SYNTHESIS
  logic [NUM_SRC-1:0]               pend_q;
  logic [NUM_SRC*THREAD_NUM*32-1:0] data_q;
  logic [NUM_SRC*WARP_W-1:0]        warp_q;
  logic [NUM_SRC*REG_W-1:0]         reg_q;
  logic [NUM_SRC*THREAD_NUM-1:0]    mask_q;

  // A request left ungranted last cycle must still be present, unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      data_q <= '0;
      warp_q <= '0;
      reg_q  <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= src_valid & ~src_grant;
      data_q <= src_data;
      warp_q <= src_warp;
      reg_q  <= src_reg;
      mask_q <= src_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state != IDLE && state != HOLD)
        $fatal(1, "gelato_wb_arbiter: illegal state %b", state);
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (pend_q[i]) begin
          assert (src_valid[i] &&
                  src_data[i*DATA_W +: DATA_W] == data_q[i*DATA_W +: DATA_W] &&
                  src_warp[i*WARP_W +: WARP_W] == warp_q[i*WARP_W +: WARP_W] &&
                  src_reg[i*REG_W +: REG_W] == reg_q[i*REG_W +: REG_W] &&
                  src_mask[i*THREAD_NUM +: THREAD_NUM] == mask_q[i*THREAD_NUM +: THREAD_NUM])
            else $error("gelato_wb_arbiter: source %0d dropped or changed before grant", i);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Bench for gelato_wb_arbiter: directed scenarios with literal expectations plus a
// transaction-level model compared against the DUT on every falling clock edge.
module tb_gelato_wb_arbiter;
  localparam int NS = 3;
  localparam int TN = 32;
  localparam int WW = 5;
  localparam int RW = 5;
  localparam int DW = TN * 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rdy = 1'b1;
  logic              wb_caught = 1'b0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NS*WW-1:0]  src_warp = '0;
  logic [NS*RW-1:0]  src_reg = '0;
  logic [NS*TN-1:0]  src_mask = '0;
  logic [NS-1:0]     src_grant;
  logic              wb_valid;
  logic [DW-1:0]     wb_data;
  logic [WW-1:0]     wb_warp;
  logic [RW-1:0]     wb_reg;
  logic [TN-1:0]     wb_mask;
  logic [31:0]       wb_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [NS-1:0] keep = '0;
  int tag [NS];

  always #5 clk = ~clk;

  gelato_wb_arbiter #(.NUM_SRC(NS), .THREAD_NUM(TN), .WARP_W(WW), .REG_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .src_valid(src_valid), .src_data(src_data), .src_warp(src_warp),
    .src_reg(src_reg), .src_mask(src_mask), .src_grant(src_grant),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_warp(wb_warp),
    .wb_reg(wb_reg), .wb_mask(wb_mask), .wb_caught(wb_caught),
    .wb_count(wb_count)
  );

  // Model: one pending entry, the index of the last winner, and a consume tally.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [WW-1:0] m_warp = '0;
  logic [RW-1:0] m_reg = '0;
  logic [TN-1:0] m_mask = '0;
  int            m_last = NS - 1;
  logic [31:0]   m_cnt = '0;
  logic [31:0]   m_base = '0;

  function automatic int pick();
    if (!rst_n || !rdy || (m_valid && !wb_caught)) return -1;
    for (int k = 1; k <= NS; k++) begin
      int j;
      j = (m_last + k) % NS;
      if (src_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] onehot(input int j);
    logic [NS-1:0] v;
    v = '0;
    if (j >= 0) v[j] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int j;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_warp  = '0;
      m_reg   = '0;
      m_mask  = '0;
      m_last  = NS - 1;
      m_cnt   = '0;
    end else if (rdy) begin
      j = pick();
      if (m_valid && wb_caught) m_cnt = m_cnt + 32'd1;
      if (j >= 0) begin
        m_valid = 1'b1;
        m_data  = src_data[j*DW +: DW];
        m_warp  = src_warp[j*WW +: WW];
        m_reg   = src_reg[j*RW +: RW];
        m_mask  = src_mask[j*TN +: TN];
        m_last  = j;
      end else if (m_valid && wb_caught) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [NS-1:0] eg;
    eg = onehot(pick());
    n_checks++;
    if (src_grant !== eg) begin
      n_errors++;
      $display("FAIL model_grant t=%0t: got %b expected %b", $time, src_grant, eg);
    end
    n_checks++;
    if (wb_valid !== m_valid) begin
      n_errors++;
      $display("FAIL model_valid t=%0t: got %b expected %b", $time, wb_valid, m_valid);
    end
    n_checks++;
    if (wb_count !== m_base + m_cnt) begin
      n_errors++;
      $display("FAIL model_count t=%0t: got %0d expected %0d", $time, wb_count, m_base + m_cnt);
    end
    n_checks++;
    if ({wb_data, wb_warp, wb_reg, wb_mask} !== {m_data, m_warp, m_reg, m_mask}) begin
      n_errors++;
      $display("FAIL model_payload t=%0t: got warp %0d reg %0d mask %h data %h, expected warp %0d reg %0d mask %h data %h",
               $time, wb_warp, wb_reg, wb_mask, wb_data[63:0], m_warp, m_reg, m_mask, m_data[63:0]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic load(input int s, input logic [WW-1:0] w, input logic [RW-1:0] r,
                      input logic [TN-1:0] m);
    for (int l = 0; l < TN; l++)
      src_data[(s*TN + l)*32 +: 32] = {8'(s), 8'(tag[s]), 16'(l)};
    src_warp[s*WW +: WW] = w;
    src_reg[s*RW +: RW]  = r;
    src_mask[s*TN +: TN] = m;
    src_valid[s] = 1'b1;
  endtask

  // One clock: samples this cycle's grant, then retires or refreshes granted sources.
  task automatic cyc(output logic [NS-1:0] g);
    #1 g = src_grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (g[i]) begin
        if (keep[i]) begin
          tag[i]++;
          load(i, WW'(tag[i]), RW'(tag[i] + i), ~TN'(tag[i]));
        end else begin
          src_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [NS-1:0] g;
    for (int i = 0; i < NS; i++) tag[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(wb_valid), 64'd0);
    chk("reset_count", 64'(wb_count), 64'd0);
    chk("reset_grant", 64'(src_grant), 64'd0);
    rst_n = 1'b1;

    // Fairness: all sources requesting, consumed every cycle.
    wb_caught = 1'b1;
    keep = '1;
    for (int i = 0; i < NS; i++) load(i, WW'(i), RW'(i), '1);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) keep = '0;
      cyc(g);
      chk("rr_order", 64'(g), 64'(onehot(k % 3)));
      if (k == 0) chk("rr_latency", 64'(wb_valid), 64'd1);
    end
    cyc(g);
    chk("rr_tail_grant", 64'(g), 64'd0);
    chk("rr_count", 64'(wb_count), 64'd6);
    chk("rr_idle", 64'(wb_valid), 64'd0);

    // Single request from source 1.
    load(1, 5'd4, 5'd7, '1);
    cyc(g);
    chk("single_grant", 64'(g), 64'b010);
    chk("single_valid", 64'(wb_valid), 64'd1);
    chk("single_warp", 64'(wb_warp), 64'd4);
    chk("single_reg", 64'(wb_reg), 64'd7);
    chk("single_mask", 64'(wb_mask), 64'hFFFF_FFFF);
    cyc(g);
    chk("single_nogrant", 64'(g), 64'd0);
    chk("single_idle", 64'(wb_valid), 64'd0);
    chk("single_count", 64'(wb_count), 64'd7);

    // Backpressure: source 2 entry held while source 0 waits.
    wb_caught = 1'b0;
    load(2, 5'd9, 5'd3, 32'hA5A5_5A5A);
    cyc(g);
    chk("bp_grant2", 64'(g), 64'b100);
    load(0, 5'd1, 5'd1, '1);
    repeat (5) begin
      cyc(g);
      chk("bp_nogrant", 64'(g), 64'd0);
      chk("bp_warp_hold", 64'(wb_warp), 64'd9);
    end
    wb_caught = 1'b1;
    cyc(g);
    chk("bp_release_grant", 64'(g), 64'b001);
    chk("bp_new_warp", 64'(wb_warp), 64'd1);
    chk("bp_count", 64'(wb_count), 64'd8);
    cyc(g);
    chk("bp_drain_count", 64'(wb_count), 64'd9);

    // rdy freeze with an entry pending.
    wb_caught = 1'b0;
    load(0, 5'd11, 5'd2, '1);
    load(1, 5'd12, 5'd2, '1);
    load(2, 5'd13, 5'd2, '1);
    cyc(g);
    chk("frz_first", 64'(g), 64'b010);
    rdy = 1'b0;
    wb_caught = 1'b1;
    repeat (3) begin
      cyc(g);
      chk("frz_nogrant", 64'(g), 64'd0);
      chk("frz_count", 64'(wb_count), 64'd9);
      chk("frz_warp", 64'(wb_warp), 64'd12);
    end
    rdy = 1'b1;
    cyc(g);
    chk("frz_resume1", 64'(g), 64'b100);
    cyc(g);
    chk("frz_resume2", 64'(g), 64'b001);
    cyc(g);
    chk("frz_count_end", 64'(wb_count), 64'd12);

    // Reset while an entry is pending.
    wb_caught = 1'b0;
    load(1, 5'd20, 5'd20, '1);
    cyc(g);
    chk("rst_pre_grant", 64'(g), 64'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_now", 64'(wb_valid), 64'd0);
    chk("rst_count_now", 64'(wb_count), 64'd0);
    src_valid = '0;
    load(0, 5'd21, 5'd21, '1);
    load(2, 5'd22, 5'd22, '1);
    wb_caught = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(g);
    chk("rst_first", 64'(g), 64'b001);
    cyc(g);
    chk("rst_second", 64'(g), 64'b100);
    cyc(g);
    chk("rst_count", 64'(wb_count), 64'd2);

    // Zero thread mask passes through.
    load(0, 5'd3, 5'd3, '0);
    cyc(g);
    chk("zmask_grant", 64'(g), 64'b001);
    chk("zmask_valid", 64'(wb_valid), 64'd1);
    chk("zmask_mask", 64'(wb_mask), 64'd0);
    cyc(g);
    chk("zmask_count", 64'(wb_count), 64'd3);

    // Counter wrap.
    force dut.count_q = 32'hFFFF_FFFF;
    m_base = 32'hFFFF_FFFF - m_cnt;
    #1 release dut.count_q;
    chk("wrap_preload", 64'(wb_count), 64'hFFFF_FFFF);
    load(1, 5'd30, 5'd30, '1);
    cyc(g);
    chk("wrap_grant", 64'(g), 64'b010);
    cyc(g);
    chk("wrap_count", 64'(wb_count), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
